// File: rtl/cnn_pkg.sv
// Shared defaults, FSM encoding and window-count constant for the conv window fetcher.
// WD normally comes from global.sv; a fallback keeps this slice self-contained.
`ifndef WD
`define WD 7
`endif

package cnn_pkg;
  localparam int IMG_W_DEF = 28;
  localparam int IMG_H_DEF = 28;
  localparam int K_DEF     = 3;
  localparam int DW        = `WD + 1;

`ifdef CONV_WIN_ZERO_PAD_EN
  localparam int NUM_WIN_DEF = IMG_W_DEF * IMG_H_DEF;
`else
  localparam int NUM_WIN_DEF = (IMG_W_DEF - K_DEF + 1) * (IMG_H_DEF - K_DEF + 1);
`endif

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_CAPT  = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;
endpackage

// File: rtl/conv_win_addr_gen.sv
// Row/col/tap counters and ROM tap address for the window fetcher.
// CONV_WIN_ZERO_PAD_EN switches to a centred, one-pixel zero-padded grid.
module conv_win_addr_gen
  import cnn_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int K     = K_DEF,
  parameter int TW    = $clog2(K*K)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          clr,
  input  logic          tap_inc,
  input  logic          win_adv,
  output logic [TW-1:0] tap,
  output logic [4:0]    row,
  output logic [4:0]    col,
  output logic [11:0]   addr,
  output logic          oob,
  output logic          last_tap,
  output logic          last_win
);
  localparam int KW = $clog2(K+1);
`ifdef CONV_WIN_ZERO_PAD_EN
  localparam logic [4:0] ROW_MAX = 5'(IMG_H - 1);
  localparam logic [4:0] COL_MAX = 5'(IMG_W - 1);
`else
  localparam logic [4:0] ROW_MAX = 5'(IMG_H - K);
  localparam logic [4:0] COL_MAX = 5'(IMG_W - K);
`endif

  logic [KW-1:0] ti, tj;
  logic [11:0]   pr, pc;

  assign last_tap = (tap == TW'(K*K-1));
  assign last_win = (row == ROW_MAX) && (col == COL_MAX);

  always_ff @(posedge clk) begin
    if (!rstn || clr) begin
      tap <= '0;
      ti  <= '0;
      tj  <= '0;
      row <= '0;
      col <= '0;
    end else begin
      if (tap_inc) begin
        if (last_tap) begin
          tap <= '0;
          ti  <= '0;
          tj  <= '0;
        end else begin
          tap <= tap + 1'b1;
          if (tj == KW'(K-1)) begin
            tj <= '0;
            ti <= ti + 1'b1;
          end else begin
            tj <= tj + 1'b1;
          end
        end
      end
      if (win_adv) begin
        if (col == COL_MAX) begin
          col <= '0;
          row <= (row == ROW_MAX) ? 5'd0 : row + 5'd1;
        end else begin
          col <= col + 5'd1;
        end
      end
    end
  end

  always_comb begin
    pr = 12'(row) + 12'(ti);
    pc = 12'(col) + 12'(tj);
`ifdef CONV_WIN_ZERO_PAD_EN
    // pr/pc are pixel coordinates +1, so 0 and IMG+1 are the padding ring
    oob  = (pr == 12'd0) || (pr > 12'(IMG_H)) || (pc == 12'd0) || (pc > 12'(IMG_W));
    addr = (pr - 12'd1) * 12'(IMG_W) + pc - 12'd1;
`else
    oob  = 1'b0;
    addr = pr * 12'(IMG_W) + pc;
`endif
  end
endmodule

// File: rtl/conv_win_fetch.sv
// Re-reads each KxK window from the image ROM and presents it on valid/ready.
// CONV_WIN_ZERO_PAD_EN enables the zero-padded IMG_H x IMG_W output grid.
module conv_win_fetch
  import cnn_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int K     = K_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  output logic              cena,
  output logic [11:0]       aa,
  input  logic [DW-1:0]     qa,
  output logic              win_valid,
  input  logic              win_ready,
  output logic [K*K*DW-1:0] win_data,
  output logic [4:0]        win_row,
  output logic [4:0]        win_col,
  output logic              busy,
  output logic              done
);
  localparam int TW = $clog2(K*K);

  logic [2:0]    state;
  logic [TW-1:0] tap, rd_slot;
  logic [11:0]   addr;
  logic          oob, last_tap, last_win;
  logic          rd_vld, rd_oob;
  logic          fetch, hs;

  assign fetch = (state == ST_FETCH);
  assign hs    = (state == ST_HOLD) && win_valid && win_ready;
  assign cena  = !(fetch && !oob);
  assign aa    = fetch ? addr : 12'd0;
  assign busy  = (state == ST_FETCH) || (state == ST_CAPT) || (state == ST_HOLD);
  assign done  = (state == ST_DONE);

  conv_win_addr_gen #(.IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .TW(TW)) u_addr (
    .clk      (clk),
    .rstn     (rstn),
    .clr      ((state == ST_IDLE) && start),
    .tap_inc  (fetch),
    .win_adv  (hs),
    .tap      (tap),
    .row      (win_row),
    .col      (win_col),
    .addr     (addr),
    .oob      (oob),
    .last_tap (last_tap),
    .last_win (last_win)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= ST_IDLE;
      win_valid <= 1'b0;
      win_data  <= '0;
      rd_vld    <= 1'b0;
      rd_slot   <= '0;
      rd_oob    <= 1'b0;
    end else begin
      // ROM data lags the issued tap by one cycle; track which slot it belongs to
      rd_vld  <= fetch;
      rd_slot <= tap;
      rd_oob  <= oob;
      for (int s = 0; s < K*K; s++)
        if (rd_vld && rd_slot == TW'(s))
          win_data[s*DW +: DW] <= rd_oob ? '0 : qa;
      case (state)
        ST_IDLE:  if (start) state <= ST_FETCH;
        ST_FETCH: if (last_tap) state <= ST_CAPT;
        ST_CAPT: begin
          state     <= ST_HOLD;
          win_valid <= 1'b1;
        end
        ST_HOLD: if (win_valid && win_ready) begin
          win_valid <= 1'b0;
          state     <= last_win ? ST_DONE : ST_FETCH;
        end
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: doc/conv_win_fetch.md
Name: conv_win_fetch

Overview:
- Sits directly downstream of the source-image ROM; starts when the ROM's load-complete `ready` pulse arrives.
- Reads the stored 28x28 image through the ROM's registered read port (`cena` active-low, `aa`, `qa`).
- Assembles each KxK convolution window, one position at a time, row-major, and presents it to the conv engine on a valid/ready handshake.
- No line buffer: every window is re-read from the ROM.

Parameters:
- IMG_W, 28, image width in pixels.
- IMG_H, 28, image height in pixels.
- K, 3, kernel size (square).
- Data width is DW = `WD+1 from global.sv; it is not a parameter.

Ports:
- clk  in  1  clock.
- rstn  in  1  synchronous active-low reset.
- start  in  1  one-cycle pulse; connect to the ROM `ready` output.
- cena  out  1  ROM read enable, active-low.
- aa  out  12  ROM read address.
- qa  in  DW  ROM read data; valid the cycle after `cena`=0.
- win_valid  out  1  window available.
- win_ready  in  1  downstream accepts the window.
- win_data  out  K*K*DW  tap (i,j) occupies bits [(i*K+j)*DW +: DW]; i = row offset, j = column offset.
- win_row  out  5  output row index of the current window.
- win_col  out  5  output column index of the current window.
- busy  out  1  high from the cycle after `start` until `done`.
- done  out  1  one-cycle pulse after the last window is accepted.

Behaviour:
- Reset state: cena=1, aa=0, win_valid=0, win_data=0, win_row=0, win_col=0, busy=0, done=0, FSM=IDLE.
- Reset asserted mid-operation aborts immediately; the FSM returns to IDLE and no `done` pulse is produced.
- Output grid (no padding): rows 0..IMG_H-K, columns 0..IMG_W-K. Default is 26x26 = 676 windows.
- Tap address: (win_row+i)*IMG_W + (win_col+j). Computed at 12 bits; no overflow is possible at the defaults.
- FSM states:
  - IDLE: on `start`, go to FETCH with tap=0, row=0, col=0. `start` is ignored in every other state.
  - FETCH: each cycle drives cena=0 and aa=addr(tap), and writes `qa` into slot tap-1, where tap-1 is the tap issued in the previous cycle. After tap K*K-1 is issued, go to CAPT.
  - CAPT: cena=1; capture the last tap; win_valid goes high on the next edge; go to HOLD.
  - HOLD: win_valid=1; win_data, win_row and win_col are held stable while win_ready=0.
    - On win_valid && win_ready, advance: col+1, wrapping to 0 with row+1.
    - If that was the last window, go to DONE; otherwise go to FETCH with tap=0 and win_valid=0 in the same edge.
  - DONE: pulse `done` for one cycle, busy=0, return to IDLE.
- Timing: win_valid first rises K*K+1 = 10 edges after the edge that samples `start`. Throughput is K*K+2 = 11 cycles per window when win_ready is tied high.
- cena is high in IDLE, CAPT, HOLD and DONE.
- win_ready while win_valid=0 is ignored.

Optional Feature:
- Macro: CONV_WIN_ZERO_PAD_EN.
- When defined: one-pixel zero padding. The output grid becomes IMG_H x IMG_W (784 windows), centred at (win_row, win_col), with tap (i,j) reading pixel (win_row+i-1, win_col+j-1).
  - Out-of-bounds taps keep cena=1 for that FETCH cycle, and their slot is loaded with 0.
  - Cycle timing is unchanged.
- When undefined: unpadded behaviour as above, and no boundary-compare logic is synthesized.

Decomposition:
- Shared package (cnn_pkg): IMG_W/IMG_H/K defaults, the FSM state enum, and the window-count constant.
- One sub-module: conv_win_addr_gen.
  - Holds the row/col/tap counters and computes the address.
  - Flags out-of-bounds taps when CONV_WIN_ZERO_PAD_EN is defined.
  - Flags `last_tap` and `last_win`.
- The top level owns the FSM, the window register and the handshake.

Test Plan:
- ROM model loaded with pixel[a] = a mod 256; pulse start; win_ready=1 -> first window taps = 0,1,2,28,29,30,56,57,58; win_valid first high 10 cycles after start; row=0, col=0.
- Run to completion -> 676 handshakes; last window (25,25) taps = 725,726,727,753,754,755,781,782,783 (mod 256 applied); done pulses exactly once; busy then drops.
- Hold win_ready=0 for 20 cycles at window (3,7) -> win_data, win_row and win_col stay stable and no ROM reads occur (cena=1); after release, next window is (3,8).
- Pulse start again while busy -> ignored; window count is still 676 and the address sequence is unperturbed.
- Assert rstn=0 during window (10,4) FETCH -> next cycle all outputs hold reset values; a new start restarts at (0,0).
- With CONV_WIN_ZERO_PAD_EN: window (0,0) taps = 0,0,0,0,0,1,0,28,29; cena is high for the 5 padded tap cycles; done fires after 784 windows.
